axi_dw_w_serializer: RTL and testbench
======================================

Name: axi_dw_w_serializer

Overview:
- Parametrised W-channel serializer for the next-generation data-width downsizer.
- Takes one wide slave-port W beat plus a per-beat lane window (first and last narrow lane), computed upstream from the AW address, size and len.
- Emits one narrow master-port W beat per lane in that window, in ascending lane order.
- Adds three things a fixed split does not have: arbitrary lane windows (narrow and unaligned bursts), zero-bubble back-to-back operation, and a synchronous clear.

Parameters:
- SlvDataWidth, 64, wide input data width in bits.
- MstDataWidth, 32, narrow output data width in bits.
- UserWidth, 1, W user width, passed through unchanged.
- Ratio, SlvDataWidth/MstDataWidth, derived; number of narrow lanes.
- LaneIdxWidth, $clog2(Ratio), derived.
- Elaboration error unless Ratio is a power of two >= 2 and MstDataWidth >= 8.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- clr_i  in  1  synchronous clear; drops any buffered beat
- slv_w_data_i  in  SlvDataWidth  wide data
- slv_w_strb_i  in  SlvDataWidth/8  wide strobe
- slv_w_last_i  in  1  wide beat closes the burst
- slv_w_user_i  in  UserWidth  user
- slv_w_lo_i  in  LaneIdxWidth  first lane to emit
- slv_w_hi_i  in  LaneIdxWidth  last lane to emit
- slv_w_valid_i  in  1  wide beat valid
- slv_w_ready_o  out  1  wide beat accepted
- mst_w_data_o  out  MstDataWidth  narrow data
- mst_w_strb_o  out  MstDataWidth/8  narrow strobe
- mst_w_last_o  out  1  narrow last
- mst_w_user_o  out  UserWidth  user
- mst_w_valid_o  out  1  narrow beat valid
- mst_w_ready_i  in  1  narrow beat accepted

Behaviour:
- Clock and reset: single clock clk_i; reset rst_ni is asynchronous, active-low.
- State: one wide buffer (data, strb, last, user, hi) plus lane counter idx and a valid flag.
- FSM has two states:
  - EMPTY: buffer invalid.
  - SERIAL: buffer valid, idx selects the current lane.
- Reset state: EMPTY, idx=0, all buffer registers 0.
- Reset output values: mst_w_valid_o=0, mst_w_data_o=0, mst_w_strb_o=0, mst_w_last_o=0, mst_w_user_o=0, slv_w_ready_o=1.
- Outputs are driven from registers; no combinational path from slave data or valid to master outputs.
  - mst_w_valid_o = (state==SERIAL).
  - mst_w_data_o = buf_data[idx*MstDataWidth +: MstDataWidth].
  - mst_w_strb_o = the same slice of buf_strb.
  - mst_w_last_o = buf_last && (idx==buf_hi).
  - mst_w_user_o = buf_user on every narrow beat.
- Ready: slv_w_ready_o = EMPTY || (SERIAL && idx==buf_hi && mst_w_ready_i). This is the only combinational ready path.
- Accept (slv_w_valid_i && slv_w_ready_o):
  - load the buffer and set idx=slv_w_lo_i;
  - if slv_w_lo_i > slv_w_hi_i, store buf_hi=slv_w_lo_i, i.e. emit a single lane lo;
  - go to SERIAL.
- Narrow handshake with idx != buf_hi: idx+1, stay in SERIAL.
- Narrow handshake with idx == buf_hi:
  - with a simultaneous accept: reload the buffer in the same cycle (zero bubble, full throughput);
  - otherwise: go to EMPTY.
- Latency: first narrow beat is valid one cycle after the wide handshake.
- Throughput: (hi-lo+1) narrow beats per wide beat, with no idle cycle between wide beats when the input stays valid.
- Backpressure: while mst_w_valid_o=1 and mst_w_ready_i=0, all master outputs stay stable (AXI valid/ready stability).
- Strobes are forwarded verbatim, including all-zero lanes inside the window; lanes outside the window are never emitted.
- clr_i:
  - forces EMPTY and idx=0 next cycle and discards the buffered beat;
  - a wide beat presented in the same cycle is not accepted (slv_w_ready_o=0 while clr_i=1);
  - clr_i has priority over every handshake.
- Reset mid-burst: immediate return to the reset state; partially sent beats are lost. Upstream owns burst recovery.

Test Plan:
- 64->32, lo=0 hi=1, data=0x1122_3344_5566_7788, strb=0xFF, last=1 -> two beats: 0x5566_7788/0xF/last=0, then 0x1122_3344/0xF/last=1.
- 128->32, lo=1 hi=2, strb=0x0FF0 -> exactly two beats, lane1 then lane2, strb 0xF each, last on lane2 only.
- lo=3 hi=1 (inverted), 128->32 -> single beat from lane 3, last=buf_last.
- Back-to-back: 4 wide beats (lo=0 hi=1) with input always valid and mst_w_ready_i=1 -> 8 narrow beats in 8 consecutive cycles, slv_w_ready_o high on cycles 2,4,6.
- Random mst_w_ready_i stalls (50%) -> master outputs stable while stalled; scoreboard matches the lane sequence exactly.
- clr_i asserted mid-serialisation (idx=1 of 0..3), and separately rst_ni pulsed low asynchronously -> mst_w_valid_o=0 next cycle (clr) or immediately (reset); the next accepted beat restarts at its own lo.

Source files
------------

// File: rtl/axi_dw_w_serializer.sv
// W-channel serializer for the data-width downsizer: splits one wide W beat into
// one narrow beat per lane of an upstream-computed lane window, lowest lane first.
module axi_dw_w_serializer #(
   parameter int unsigned  SlvDataWidth = 64,
   parameter int unsigned  MstDataWidth = 32,
   parameter int unsigned  UserWidth    = 1,
   localparam int unsigned Ratio        = SlvDataWidth / MstDataWidth,
   localparam int unsigned LaneIdxWidth = (Ratio > 1) ? $clog2(Ratio) : 1
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      clr_i,
   input  logic [SlvDataWidth-1:0]   slv_w_data_i,
   input  logic [SlvDataWidth/8-1:0] slv_w_strb_i,
   input  logic                      slv_w_last_i,
   input  logic [UserWidth-1:0]      slv_w_user_i,
   input  logic [LaneIdxWidth-1:0]   slv_w_lo_i,
   input  logic [LaneIdxWidth-1:0]   slv_w_hi_i,
   input  logic                      slv_w_valid_i,
   output logic                      slv_w_ready_o,
   output logic [MstDataWidth-1:0]   mst_w_data_o,
   output logic [MstDataWidth/8-1:0] mst_w_strb_o,
   output logic                      mst_w_last_o,
   output logic [UserWidth-1:0]      mst_w_user_o,
   output logic                      mst_w_valid_o,
   input  logic                      mst_w_ready_i
);

   localparam int unsigned MstStrbWidth = MstDataWidth / 8;

   if (!((Ratio >= 2) && ((Ratio & (Ratio - 1)) == 0) && (MstDataWidth >= 8) &&
         (MstDataWidth % 8 == 0) && (Ratio * MstDataWidth == SlvDataWidth))) begin : gen_param_err
      $error("axi_dw_w_serializer: Ratio must be a power of two >= 2 and MstDataWidth >= 8");
   end

   typedef enum logic {
      EMPTY  = 1'b0,
      SERIAL = 1'b1
   } state_e;

   state_e                             state_q;
   logic [Ratio-1:0][MstDataWidth-1:0] buf_data_q;
   logic [Ratio-1:0][MstStrbWidth-1:0] buf_strb_q;
   logic                               buf_last_q;
   logic [UserWidth-1:0]               buf_user_q;
   logic [LaneIdxWidth-1:0]            buf_hi_q;
   logic [LaneIdxWidth-1:0]            idx_q;

   logic at_hi;
   logic mst_hs;
   logic slv_hs;

   assign at_hi  = (idx_q == buf_hi_q);
   assign mst_hs = mst_w_valid_o && mst_w_ready_i;
   assign slv_hs = slv_w_valid_i && slv_w_ready_o;

   // Ready on the last lane's handshake lets the next wide beat load with no bubble.
   assign slv_w_ready_o = !clr_i &&
                          ((state_q == EMPTY) || ((state_q == SERIAL) && at_hi && mst_w_ready_i));

   assign mst_w_valid_o = (state_q == SERIAL);
   assign mst_w_data_o  = buf_data_q[idx_q];
   assign mst_w_strb_o  = buf_strb_q[idx_q];
   assign mst_w_last_o  = buf_last_q && at_hi;
   assign mst_w_user_o  = buf_user_q;

   // Buffer, lane counter and state; clear beats every handshake, accept beats narrow progress.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= EMPTY;
         idx_q      <= '0;
         buf_data_q <= '0;
         buf_strb_q <= '0;
         buf_last_q <= 1'b0;
         buf_user_q <= '0;
         buf_hi_q   <= '0;
      end else if (clr_i) begin
         state_q    <= EMPTY;
         idx_q      <= '0;
         buf_data_q <= '0;
         buf_strb_q <= '0;
         buf_last_q <= 1'b0;
         buf_user_q <= '0;
         buf_hi_q   <= '0;
      end else if (slv_hs) begin
         state_q    <= SERIAL;
         idx_q      <= slv_w_lo_i;
         buf_data_q <= slv_w_data_i;
         buf_strb_q <= slv_w_strb_i;
         buf_last_q <= slv_w_last_i;
         buf_user_q <= slv_w_user_i;
         // An inverted window collapses to the single lane lo.
         buf_hi_q   <= (slv_w_lo_i > slv_w_hi_i) ? slv_w_lo_i : slv_w_hi_i;
      end else if (mst_hs) begin
         if (at_hi) begin
            state_q <= EMPTY;
         end else begin
            idx_q <= idx_q + LaneIdxWidth'(1);
         end
      end
   end

endmodule

// File: tb/tb_axi_dw_w_serializer.sv
// Self-checking bench for axi_dw_w_serializer in a 128->32 configuration with a
// queue-based beat model plus directed literal expectations.
module tb_axi_dw_w_serializer;

   localparam int unsigned SW  = 128;
   localparam int unsigned MW  = 32;
   localparam int unsigned UW  = 2;
   localparam int unsigned LW  = 2;
   localparam int unsigned MSW = MW / 8;
   localparam int unsigned SSW = SW / 8;

   typedef struct packed {
      logic [MW-1:0]  data;
      logic [MSW-1:0] strb;
      logic           last;
      logic [UW-1:0]  user;
   } nb_t;

   logic           clk_i;
   logic           rst_ni;
   logic           clr_i;
   logic [SW-1:0]  slv_w_data_i;
   logic [SSW-1:0] slv_w_strb_i;
   logic           slv_w_last_i;
   logic [UW-1:0]  slv_w_user_i;
   logic [LW-1:0]  slv_w_lo_i;
   logic [LW-1:0]  slv_w_hi_i;
   logic           slv_w_valid_i;
   logic           slv_w_ready_o;
   logic [MW-1:0]  mst_w_data_o;
   logic [MSW-1:0] mst_w_strb_o;
   logic           mst_w_last_o;
   logic [UW-1:0]  mst_w_user_o;
   logic           mst_w_valid_o;
   logic           mst_w_ready_i;

   axi_dw_w_serializer #(
      .SlvDataWidth(SW),
      .MstDataWidth(MW),
      .UserWidth   (UW)
   ) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .clr_i        (clr_i),
      .slv_w_data_i (slv_w_data_i),
      .slv_w_strb_i (slv_w_strb_i),
      .slv_w_last_i (slv_w_last_i),
      .slv_w_user_i (slv_w_user_i),
      .slv_w_lo_i   (slv_w_lo_i),
      .slv_w_hi_i   (slv_w_hi_i),
      .slv_w_valid_i(slv_w_valid_i),
      .slv_w_ready_o(slv_w_ready_o),
      .mst_w_data_o (mst_w_data_o),
      .mst_w_strb_o (mst_w_strb_o),
      .mst_w_last_o (mst_w_last_o),
      .mst_w_user_o (mst_w_user_o),
      .mst_w_valid_o(mst_w_valid_o),
      .mst_w_ready_i(mst_w_ready_i)
   );

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   int  total_cnt = 0;
   int  pass_cnt  = 0;
   int  cyc       = 0;
   logic rand_mode = 1'b0;

   nb_t model_q[$];   // narrow beats still owed by the DUT
   nb_t log_q[$];     // narrow beats actually handed over by the DUT
   int  hs_cyc[$];

   function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endfunction

   function automatic nb_t nb(input logic [MW-1:0] d, input logic [MSW-1:0] s,
                              input logic l, input logic [UW-1:0] u);
      nb_t b;
      b.data = d;
      b.strb = s;
      b.last = l;
      b.user = u;
      return b;
   endfunction

   // Expected narrow beats for one accepted wide beat.
   function automatic void push_beats(input logic [SW-1:0] d, input logic [SSW-1:0] s, input logic l,
                                      input logic [UW-1:0] u, input logic [LW-1:0] lo,
                                      input logic [LW-1:0] hi);
      int first   = int'(lo);
      int final_l = (lo > hi) ? int'(lo) : int'(hi);
      for (int k = first; k <= final_l; k++) begin
         model_q.push_back(nb(d[k*MW +: MW], s[k*MSW +: MSW], l && (k == final_l), u));
      end
   endfunction

   nb_t  act;
   nb_t  prev_out;
   logic prev_stall = 1'b0;
   logic exp_valid;
   logic exp_ready;

   // Compare process: checks every cycle at the falling edge, then advances the model.
   always @(negedge clk_i) begin
      cyc++;
      act = {mst_w_data_o, mst_w_strb_o, mst_w_last_o, mst_w_user_o};
      if (!rst_ni) begin
         model_q.delete();
         prev_stall = 1'b0;
         chk("rst_outputs", 128'(act), 128'(0));
         chk("rst_valid", 128'(mst_w_valid_o), 128'(0));
         chk("rst_ready", 128'(slv_w_ready_o), 128'(1));
      end else begin
         exp_valid = (model_q.size() > 0);
         exp_ready = !clr_i && ((model_q.size() == 0) || ((model_q.size() == 1) && mst_w_ready_i));
         chk("ready", 128'(slv_w_ready_o), 128'(exp_ready));
         chk("valid", 128'(mst_w_valid_o), 128'(exp_valid));
         if (exp_valid) chk("beat", 128'(act), 128'(model_q[0]));
         if (prev_stall) chk("stall_stable", 128'(act), 128'(prev_out));
         prev_stall = mst_w_valid_o && !mst_w_ready_i && !clr_i;
         prev_out   = act;
         if (clr_i) begin
            model_q.delete();
         end else begin
            if (mst_w_valid_o && mst_w_ready_i) begin
               log_q.push_back(act);
               hs_cyc.push_back(cyc);
            end
            if (exp_valid && mst_w_ready_i) void'(model_q.pop_front());
            if (slv_w_valid_i && exp_ready)
               push_beats(slv_w_data_i, slv_w_strb_i, slv_w_last_i, slv_w_user_i, slv_w_lo_i, slv_w_hi_i);
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk_i);
         #1;
         if (rand_mode) mst_w_ready_i = 1'($urandom_range(0, 1));
      end
   end

   task automatic send(input logic [SW-1:0] d, input logic [SSW-1:0] s, input logic l,
                       input logic [UW-1:0] u, input logic [LW-1:0] lo, input logic [LW-1:0] hi);
      logic acc;
      int   n;
      acc = 1'b0;
      n   = 0;
      slv_w_data_i  = d;
      slv_w_strb_i  = s;
      slv_w_last_i  = l;
      slv_w_user_i  = u;
      slv_w_lo_i    = lo;
      slv_w_hi_i    = hi;
      slv_w_valid_i = 1'b1;
      do begin
         @(negedge clk_i);
         acc = slv_w_ready_o;
         @(posedge clk_i);
         #1;
         n++;
      end while (!acc && n < 200);
      chk("accept_timeout", 128'(acc), 128'(1));
      slv_w_valid_i = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((mst_w_valid_o || model_q.size() > 0) && n < 300) begin
         @(posedge clk_i);
         #1;
         n++;
      end
      chk("drain_timeout", 128'(mst_w_valid_o), 128'(0));
   endtask

   localparam logic [SW-1:0] D_LANES = 128'h44444444_33333333_22222222_11111111;
   localparam logic [SW-1:0] D_CLR   = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
   localparam logic [SW-1:0] D_NEW   = 128'h87654321_0BADF00D_CAFEBABE_DEADBEEF;

   initial begin
      rst_ni        = 1'b0;
      clr_i         = 1'b0;
      slv_w_data_i  = '0;
      slv_w_strb_i  = '0;
      slv_w_last_i  = 1'b0;
      slv_w_user_i  = '0;
      slv_w_lo_i    = '0;
      slv_w_hi_i    = '0;
      slv_w_valid_i = 1'b0;
      mst_w_ready_i = 1'b1;
      repeat (3) @(posedge clk_i);
      #1 rst_ni = 1'b1;

      // Lanes 0..1 of a 64-bit word
      log_q.delete();
      send({64'h0, 64'h1122_3344_5566_7788}, 16'h00FF, 1'b1, 2'd1, 2'd0, 2'd1);
      drain();
      chk("t1_count", 128'(log_q.size()), 128'(2));
      if (log_q.size() == 2) begin
         chk("t1_beat0", 128'(log_q[0]), 128'(nb(32'h5566_7788, 4'hF, 1'b0, 2'd1)));
         chk("t1_beat1", 128'(log_q[1]), 128'(nb(32'h1122_3344, 4'hF, 1'b1, 2'd1)));
      end

      // Unaligned window lo=1 hi=2
      log_q.delete();
      send(D_LANES, 16'h0FF0, 1'b1, 2'd2, 2'd1, 2'd2);
      drain();
      chk("t2_count", 128'(log_q.size()), 128'(2));
      if (log_q.size() == 2) begin
         chk("t2_beat0", 128'(log_q[0]), 128'(nb(32'h2222_2222, 4'hF, 1'b0, 2'd2)));
         chk("t2_beat1", 128'(log_q[1]), 128'(nb(32'h3333_3333, 4'hF, 1'b1, 2'd2)));
      end

      // Inverted window collapses to lane lo
      log_q.delete();
      send(D_LANES, 16'hF00F, 1'b1, 2'd3, 2'd3, 2'd1);
      drain();
      chk("t3_count", 128'(log_q.size()), 128'(1));
      if (log_q.size() == 1)
         chk("t3_beat0", 128'(log_q[0]), 128'(nb(32'h4444_4444, 4'hF, 1'b1, 2'd3)));

      // Back-to-back, zero bubble
      log_q.delete();
      hs_cyc.delete();
      for (int k = 0; k < 4; k++)
         send({64'h0, 32'(2 * k + 1), 32'(2 * k)}, 16'h00FF, 1'(k == 3), 2'd0, 2'd0, 2'd1);
      drain();
      chk("b2b_count", 128'(log_q.size()), 128'(8));
      if (log_q.size() == 8) begin
         chk("b2b_span", 128'(hs_cyc[7] - hs_cyc[0]), 128'(7));
         for (int j = 0; j < 8; j++) chk("b2b_data", 128'(log_q[j].data), 128'(j));
         chk("b2b_last", 128'({log_q[7].last, log_q[5].last}), 128'(2'b10));
      end

      // Clear at idx=1 of 0..3 with a competing wide beat
      log_q.delete();
      send(D_CLR, 16'hFFFF, 1'b1, 2'd0, 2'd0, 2'd3);
      @(posedge clk_i);
      #1;
      clr_i         = 1'b1;
      slv_w_data_i  = D_LANES;
      slv_w_lo_i    = 2'd0;
      slv_w_hi_i    = 2'd0;
      slv_w_valid_i = 1'b1;
      @(posedge clk_i);
      #1;
      clr_i         = 1'b0;
      slv_w_valid_i = 1'b0;
      chk("clr_valid", 128'(mst_w_valid_o), 128'(0));
      chk("clr_count", 128'(log_q.size()), 128'(1));
      send(D_NEW, 16'hFF0F, 1'b1, 2'd1, 2'd2, 2'd3);
      drain();
      chk("clr_restart_count", 128'(log_q.size()), 128'(3));
      if (log_q.size() == 3) begin
         chk("clr_lane0", 128'(log_q[0].data), 128'(32'hAAAA_AAAA));
         chk("clr_restart0", 128'(log_q[1]), 128'(nb(32'h0BAD_F00D, 4'hF, 1'b0, 2'd1)));
         chk("clr_restart1", 128'(log_q[2]), 128'(nb(32'h8765_4321, 4'hF, 1'b1, 2'd1)));
      end

      // Asynchronous reset while stalled mid-burst
      mst_w_ready_i = 1'b0;
      send(D_CLR, 16'hFFFF, 1'b1, 2'd0, 2'd0, 2'd3);
      @(posedge clk_i);
      #2 rst_ni = 1'b0;
      #1;
      chk("arst_valid", 128'(mst_w_valid_o), 128'(0));
      chk("arst_data", 128'(mst_w_data_o), 128'(0));
      @(posedge clk_i);
      #1;
      rst_ni        = 1'b1;
      mst_w_ready_i = 1'b1;
      log_q.delete();
      send(D_NEW, 16'h00F0, 1'b0, 2'd1, 2'd1, 2'd1);
      drain();
      chk("arst_count", 128'(log_q.size()), 128'(1));
      if (log_q.size() == 1)
         chk("arst_restart", 128'(log_q[0]), 128'(nb(32'hCAFE_BABE, 4'hF, 1'b0, 2'd1)));

      // Random backpressure with varied windows
      rand_mode = 1'b1;
      for (int k = 0; k < 16; k++)
         send({$urandom, $urandom, $urandom, $urandom}, 16'($urandom), 1'(k), 2'($urandom_range(0, 3)),
              2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      rand_mode = 1'b0;
      @(posedge clk_i);
      #1 mst_w_ready_i = 1'b1;
      drain();

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
